// File: rtl/cv32e40p_ded_monitor.sv
// cv32e40p_ded_monitor: aggregates per-channel register-file DED flags into sticky
// bits, saturating counters, a first-error capture and an alert/ack interrupt FSM.
// Optional feature: define CV32E40P_DED_TIMESTAMP_EN to add a free-running cycle
// counter and the first_ts_o capture port.

// Per-channel counter and sticky bit. Lanes see clear already folded into the base.
module cv32e40p_ded_monitor_ch #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr,
  input  logic             ev,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sticky_q,
  output logic             ovf_hit
);
  logic [CNT_W-1:0] base;
  logic             sat;

  // Next count: restart from zero on clear, then apply this cycle's event.
  always_comb begin
    base    = clr ? '0 : cnt_q;
    sat     = &base;
    cnt_nxt = base;
    if (ev && !sat) cnt_nxt = base + 1'b1;
    ovf_hit = ev & sat;
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      sticky_q <= (clr ? 1'b0 : sticky_q) | ev;
    end
  end
endmodule

module cv32e40p_ded_monitor #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ALARM_THR = 1,
  parameter int unsigned TS_W      = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     enable_i,
  input  logic [NUM_CH-1:0]                        ded_i,
  input  logic                                     clear_i,
  input  logic                                     irq_ack_i,
  output logic                                     irq_o,
  output logic [NUM_CH-1:0]                        sticky_o,
  output logic [NUM_CH*CNT_W-1:0]                  cnt_o,
  output logic                                     first_valid_o,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] first_ch_o,
`ifdef CV32E40P_DED_TIMESTAMP_EN
  output logic [TS_W-1:0]                          first_ts_o,
`endif
  output logic                                     overflow_o
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] THR = CNT_W'(ALARM_THR);

  typedef enum logic [1:0] {IDLE, ALERT, HOLD} state_t;
  state_t state;

  logic [NUM_CH-1:0]            ev, ovf_hit;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_nxt;
  logic                         any_ev, alarm;
  logic [CH_W-1:0]              low_idx;

  assign ev     = ded_i & {NUM_CH{enable_i}};
  assign any_ev = |ev;
  assign cnt_o  = cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cv32e40p_ded_monitor_ch #(.CNT_W(CNT_W)) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr      (clear_i),
      .ev       (ev[k]),
      .cnt_q    (cnt_q[k]),
      .cnt_nxt  (cnt_nxt[k]),
      .sticky_q (sticky_o[k]),
      .ovf_hit  (ovf_hit[k])
    );
  end

  // Lowest firing channel and whether any next count reaches the alarm threshold.
  always_comb begin
    low_idx = '0;
    alarm   = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ev[k]) low_idx = CH_W'(k);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (cnt_nxt[k] >= THR) alarm = 1'b1;
    end
  end

  // Alert FSM; clear restarts from IDLE with this cycle's events applied.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      irq_o <= 1'b0;
    end else if (clear_i) begin
      state <= alarm ? ALERT : IDLE;
      irq_o <= alarm;
    end else begin
      case (state)
        IDLE:  if (alarm) begin state <= ALERT; irq_o <= 1'b1; end
        ALERT: if (irq_ack_i && !any_ev) begin state <= HOLD; irq_o <= 1'b0; end
        HOLD:  if (any_ev) begin state <= ALERT; irq_o <= 1'b1; end
        default: begin state <= IDLE; irq_o <= 1'b0; end
      endcase
    end
  end

  // First-error capture and sticky overflow flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_valid_o <= 1'b0;
      first_ch_o    <= '0;
      overflow_o    <= 1'b0;
    end else if (clear_i) begin
      first_valid_o <= any_ev;
      first_ch_o    <= any_ev ? low_idx : '0;
      overflow_o    <= 1'b0;
    end else begin
      if (!first_valid_o && any_ev) begin
        first_valid_o <= 1'b1;
        first_ch_o    <= low_idx;
      end
      if (|ovf_hit) overflow_o <= 1'b1;
    end
  end

`ifdef CV32E40P_DED_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running cycle stamp and its capture alongside first_valid_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      first_ts_o <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clear_i)                          first_ts_o <= any_ev ? ts_q : '0;
      else if (!first_valid_o && any_ev)    first_ts_o <= ts_q;
    end
  end
`endif
endmodule

// File: tb/tb_cv32e40p_ded_monitor.sv
// Bench for cv32e40p_ded_monitor (NUM_CH=3, CNT_W=2, ALARM_THR=1): expected output
// vectors are queued as stimulus is driven and popped after each active edge.
module tb_cv32e40p_ded_monitor;
  logic       clk = 1'b0;
  logic       rst, enable, clear, irq_ack;
  logic [2:0] ded;
  logic       irq, fv, ovf;
  logic [2:0] sticky;
  logic [5:0] cnt;
  logic [1:0] fch;
`ifdef CV32E40P_DED_TIMESTAMP_EN
  logic [31:0] first_ts;
`endif

  typedef struct packed {
    logic       irq;
    logic [2:0] sticky;
    logic [5:0] cnt;
    logic       fv;
    logic [1:0] fch;
    logic       ovf;
  } obs_t;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] ded;
    logic       clr;
    logic       ack;
  } stim_t;

  obs_t obs;
  obs_t sb[$];
  int   passed = 0;
  int   total  = 0;

  assign obs = {irq, sticky, cnt, fv, fch, ovf};

  always #5 clk = ~clk;

  cv32e40p_ded_monitor #(.NUM_CH(3), .CNT_W(2), .ALARM_THR(1), .TS_W(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .ded_i         (ded),
    .clear_i       (clear),
    .irq_ack_i     (irq_ack),
    .irq_o         (irq),
    .sticky_o      (sticky),
    .cnt_o         (cnt),
    .first_valid_o (fv),
    .first_ch_o    (fch),
`ifdef CV32E40P_DED_TIMESTAMP_EN
    .first_ts_o    (first_ts),
`endif
    .overflow_o    (ovf)
  );

  function automatic obs_t mk(logic i, logic [2:0] s, logic [5:0] c, logic v, logic [1:0] f, logic o);
    return {i, s, c, v, f, o};
  endfunction

  function automatic stim_t st(logic r, logic en, logic [2:0] d, logic clr, logic ack);
    return {r, en, d, clr, ack};
  endfunction

  // Drive one cycle, queue its expected outputs, and return just after the edge.
  task automatic step(input stim_t s, input obs_t e);
    @(negedge clk);
    rst = s.rst; enable = s.en; ded = s.ded; clear = s.clr; irq_ack = s.ack;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    step(st(1, 1, 3'b000, 0, 0), '0);
    e = sb.pop_front(); total++;
    if (obs !== e) $display("FAIL reset: got %b exp %b", obs, e); else passed++;
    for (int i = 0; i < 100; i++) begin
      step(st(0, 1, 3'b000, 0, 0), '0);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL idle[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_alert();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b110,0,0), st(0,1,3'b000,0,0)};
    x = '{mk(1,3'b110,6'b010100,1,2'd1,0), mk(1,3'b110,6'b010100,1,2'd1,0)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL alert[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_ack_rearm();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b000,0,1), st(0,1,3'b000,0,1), st(0,1,3'b001,0,0),
          st(0,1,3'b001,0,1), st(0,1,3'b000,0,1)};
    x = '{mk(0,3'b110,6'b010100,1,2'd1,0), mk(0,3'b110,6'b010100,1,2'd1,0),
          mk(1,3'b111,6'b010101,1,2'd1,0), mk(1,3'b111,6'b010110,1,2'd1,0),
          mk(0,3'b111,6'b010110,1,2'd1,0)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL ack_rearm[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_saturate();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b000,1,0), st(0,1,3'b001,0,0), st(0,1,3'b001,0,0),
          st(0,1,3'b001,0,0), st(0,1,3'b001,0,0), st(0,1,3'b001,0,0)};
    x = '{mk(0,3'b000,6'b000000,0,2'd0,0), mk(1,3'b001,6'b000001,1,2'd0,0),
          mk(1,3'b001,6'b000010,1,2'd0,0), mk(1,3'b001,6'b000011,1,2'd0,0),
          mk(1,3'b001,6'b000011,1,2'd0,1), mk(1,3'b001,6'b000011,1,2'd0,1)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL saturate[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_enable();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,0,3'b111,0,0), st(0,0,3'b000,0,1), st(0,0,3'b111,0,0)};
    x = '{mk(1,3'b001,6'b000011,1,2'd0,1), mk(0,3'b001,6'b000011,1,2'd0,1),
          mk(0,3'b001,6'b000011,1,2'd0,1)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL enable[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_clear_ev();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b100,1,0), st(0,0,3'b100,1,0)};
    x = '{mk(1,3'b100,6'b010000,1,2'd2,0), mk(0,3'b000,6'b000000,0,2'd0,0)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL clear_ev[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b011,0,0), st(0,1,3'b100,0,0), st(0,1,3'b000,0,1), st(0,1,3'b000,1,0)};
    x = '{mk(1,3'b011,6'b000101,1,2'd0,0), mk(1,3'b111,6'b010101,1,2'd0,0),
          mk(0,3'b111,6'b010101,1,2'd0,0), mk(0,3'b000,6'b000000,0,2'd0,0)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL back_to_back[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

  task automatic test_reset_mid_alert();
    stim_t s[$];
    obs_t  x[$];
    obs_t  e;
    s = '{st(0,1,3'b001,0,0), st(1,1,3'b001,0,0), st(0,1,3'b000,0,0)};
    x = '{mk(1,3'b001,6'b000001,1,2'd0,0), mk(0,3'b000,6'b000000,0,2'd0,0),
          mk(0,3'b000,6'b000000,0,2'd0,0)};
    foreach (s[i]) begin
      step(s[i], x[i]);
      e = sb.pop_front(); total++;
      if (obs !== e) $display("FAIL reset_mid_alert[%0d]: got %b exp %b", i, obs, e); else passed++;
    end
  endtask

`ifdef CV32E40P_DED_TIMESTAMP_EN
  task automatic test_timestamp();
    obs_t e;
    step(st(1, 1, 3'b000, 0, 0), '0);
    e = sb.pop_front();
    for (int i = 0; i < 37; i++) begin
      step(st(0, 1, 3'b000, 0, 0), '0);
      e = sb.pop_front();
    end
    step(st(0, 1, 3'b010, 0, 0), mk(1,3'b010,6'b000100,1,2'd1,0));
    e = sb.pop_front(); total++;
    if (obs !== e || first_ts !== 32'd37)
      $display("FAIL timestamp: got %b ts %0d exp %b ts 37", obs, first_ts, e);
    else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; ded = '0; clear = 1'b0; irq_ack = 1'b0;
    test_reset();
    test_alert();
    test_ack_rearm();
    test_saturate();
    test_enable();
    test_clear_ev();
    test_back_to_back();
    test_reset_mid_alert();
`ifdef CV32E40P_DED_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
